// File: rtl/fetch_alu_accu.sv
// rtl/fetch_alu_accu.sv - instruction fetch register, 4-bit ALU and accumulator
module fetch_alu_accu (
  input  logic       clock,
  input  logic       reset,
  input  logic       fetch_en,
  input  logic [7:0] program_byte,
  input  logic [3:0] data_bus,
  input  logic [2:0] fun,
  input  logic       load_a,
  output logic [3:0] instr,
  output logic [3:0] oprnd,
  output logic [3:0] accu,
  output logic [3:0] alu,
  output logic       carry,
  output logic       zero
);

  logic [7:0] fetch_q, fetch_d;
  logic [3:0] accu_q, accu_d;
  logic [4:0] sum;

  // ALU sees only the registered accumulator, so load_a cannot form a loop
  always_comb begin
    sum = 5'd0;
    unique case (fun)
      3'b000:  sum = {1'b0, accu_q};
      3'b001:  sum = {1'b0, accu_q} + {1'b0, ~data_bus} + 5'd1;
      3'b010:  sum = {1'b0, data_bus};
      3'b011:  sum = {1'b0, accu_q} + {1'b0, data_bus};
      3'b100:  sum = {1'b0, ~(accu_q & data_bus)};
      default: sum = 5'd0;
    endcase
  end

  assign alu   = sum[3:0];
  assign carry = sum[4];
  assign zero  = (sum[3:0] == 4'd0);

  always_comb begin
    fetch_d = fetch_q;
    accu_d  = accu_q;
    if (fetch_en) fetch_d = program_byte;
    if (load_a)   accu_d  = sum[3:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_q <= 8'd0;
      accu_q  <= 4'd0;
    end else begin
      fetch_q <= fetch_d;
      accu_q  <= accu_d;
    end
  end

  assign instr = fetch_q[7:4];
  assign oprnd = fetch_q[3:0];
  assign accu  = accu_q;

endmodule

// File: tb/tb_fetch_alu_accu.sv
// tb/tb_fetch_alu_accu.sv - directed self-checking bench for fetch_alu_accu
module tb_fetch_alu_accu;

  logic       clock = 1'b0;
  logic       reset;
  logic       fetch_en;
  logic [7:0] program_byte;
  logic [3:0] data_bus;
  logic [2:0] fun;
  logic       load_a;
  logic [3:0] instr, oprnd, accu, alu;
  logic       carry, zero;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_alu_accu dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en),
    .program_byte(program_byte), .data_bus(data_bus), .fun(fun),
    .load_a(load_a), .instr(instr), .oprnd(oprnd), .accu(accu),
    .alu(alu), .carry(carry), .zero(zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; program_byte = 8'h00;
    data_bus = 4'h0; fun = 3'b000; load_a = 1'b0;
    #2;

    // reset beats both loads
    reset = 1'b0; fetch_en = 1'b1; load_a = 1'b1; program_byte = 8'hA5;
    fun = 3'b011; data_bus = 4'h3;
    tick();
    check("rst_instr", {4'h0, instr}, 8'h00);
    check("rst_oprnd", {4'h0, oprnd}, 8'h00);
    check("rst_accu",  {4'h0, accu},  8'h00);

    reset = 1'b1; fetch_en = 1'b0; load_a = 1'b0; data_bus = 4'h0;
    fun = 3'b000; settle();
    check("r000_alu", {3'b0, zero, alu}, 8'h10);
    fun = 3'b010; settle();
    check("r010_alu", {3'b0, zero, alu}, 8'h10);
    fun = 3'b011; settle();
    check("r011_alu", {2'b0, carry, zero, alu}, 8'h10);
    fun = 3'b100; settle();
    check("r100_alu", {3'b0, zero, alu}, 8'h0F);
    fun = 3'b001; settle();
    check("r001_alu", {2'b0, carry, zero, alu}, 8'h30);

    // fetch capture then hold
    fetch_en = 1'b1; program_byte = 8'h3C; settle();
    check("fetch_not_comb", {instr, oprnd}, 8'h00);
    tick();
    check("fetch_3c", {instr, oprnd}, 8'h3C);
    fetch_en = 1'b0; program_byte = 8'hFF;
    tick();
    check("fetch_hold", {instr, oprnd}, 8'h3C);

    // 9 + 9
    fun = 3'b010; data_bus = 4'h9; load_a = 1'b1;
    tick();
    check("accu_9", {4'h0, accu}, 8'h09);
    load_a = 1'b0; fun = 3'b011; settle();
    check("add_9_9", {2'b0, carry, zero, alu}, 8'h22);
    load_a = 1'b1;
    tick();
    check("accu_add", {4'h0, accu}, 8'h02);
    fun = 3'b000;
    tick();
    check("accu_feedback", {4'h0, accu}, 8'h02);

    // compare
    fun = 3'b010; data_bus = 4'h5;
    tick();
    load_a = 1'b0; fun = 3'b001; settle();
    check("sub_5_5", {2'b0, carry, zero, alu}, 8'h30);
    data_bus = 4'h7; settle();
    check("sub_5_7", {2'b0, carry, zero, alu}, 8'h0E);
    data_bus = 4'h4; settle();
    check("sub_5_4", {2'b0, carry, zero, alu}, 8'h21);

    // nand
    fun = 3'b010; data_bus = 4'hF; load_a = 1'b1;
    tick();
    load_a = 1'b0; fun = 3'b100; settle();
    check("nand_ff", {2'b0, carry, zero, alu}, 8'h10);
    data_bus = 4'h6; settle();
    check("nand_f6", {2'b0, carry, zero, alu}, 8'h09);
    fun = 3'b010; load_a = 1'b1;
    tick();
    check("accu_6", {4'h0, accu}, 8'h06);
    load_a = 1'b0;

    for (int f = 5; f < 8; f++) begin
      fun = 3'(f); data_bus = 4'hB; settle();
      check($sformatf("fun%0d_zero", f), {2'b0, carry, zero, alu}, 8'h10);
    end

    // add with no carry, and simultaneous fetch + load
    fun = 3'b011; data_bus = 4'h3; settle();
    check("add_6_3", {2'b0, carry, zero, alu}, 8'h09);
    fetch_en = 1'b1; program_byte = 8'h7E; load_a = 1'b1;
    tick();
    check("both_fetch", {instr, oprnd}, 8'h7E);
    check("both_accu", {4'h0, accu}, 8'h09);

    // reset is synchronous only
    fun = 3'b110; reset = 1'b0; settle();
    check("rst_no_async", {accu, instr}, 8'h97);
    tick();
    check("rst2_accu", {4'h0, accu}, 8'h00);
    check("rst2_fetch", {instr, oprnd}, 8'h00);

    // resume after reset release
    reset = 1'b1; fun = 3'b010; data_bus = 4'hA; program_byte = 8'h12;
    tick();
    check("resume_accu", {4'h0, accu}, 8'h0A);
    check("resume_fetch", {instr, oprnd}, 8'h12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
